// File: rtl/lab_pkg.sv
// Shared definitions for the lab memory read/write top-levels.
// Provides the scan state encoding and the default Mem geometry.
package lab_pkg;

    localparam int unsigned LAB_ADDR_W = 6;
    localparam int unsigned LAB_DATA_W = 32;

    // Scan reader states; 2-bit encoding shared with the memory top-levels.
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_STOP  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/edge_rise.sv
// One-register rising-edge detector for an already synchronised level.
// Ports:
//   clk    - clock, posedge
//   rst_n  - synchronous active-low reset (clears the history register)
//   d      - synchronised level input
//   rise_c - combinational pulse: d high this cycle, low last cycle
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    // History of the input from the previous cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/mem_scan_reader.sv
// Walks the Mem address space, reads each word and holds it on the LED
// display for a programmable dwell time. Supports free-run, pause,
// single-step and restart. Never writes Mem.
// Ports:
//   clk         - system clock, posedge
//   rst_n       - synchronous active-low reset (beats restart)
//   run         - 1 = auto-advance after DWELL cycles, 0 = paused
//   step        - synchronised single-step level, rising edge advances
//   restart     - one-cycle pulse: jump to address 0 and re-read
//   mem_addr    - read address to Mem
//   mem_rd_data - Mem read data (RD_LAT cycles after mem_addr)
//   disp_data   - captured word shown on the display
//   disp_addr   - address of disp_data
//   disp_valid  - disp_data holds a captured word
//   done        - last word shown with WRAP=0
module mem_scan_reader
    import lab_pkg::*;
#(
    parameter int unsigned ADDR_W = LAB_ADDR_W,
    parameter int unsigned DATA_W = LAB_DATA_W,
    parameter int unsigned DWELL  = 50_000_000,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WRAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic              done
);

    // A DWELL of 1 still needs a one-bit counter to keep widths legal.
    localparam int unsigned       CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    scan_state_e       state_q;
    scan_state_e       state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic [ADDR_W-1:0] daddr_d;
    logic              valid_d;
    logic              done_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              step_rise_c;
    logic              advance_c;

    // Step edge history runs in every state, so an edge outside HOLD is
    // consumed rather than queued.
    edge_rise u_step_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (step),
        .rise_c (step_rise_c)
    );

    // State, address, display and dwell counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ISSUE;
            mem_addr   <= '0;
            disp_data  <= '0;
            disp_addr  <= '0;
            disp_valid <= 1'b0;
            done       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr   <= addr_d;
            disp_data  <= data_d;
            disp_addr  <= daddr_d;
            disp_valid <= valid_d;
            done       <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state, capture and dwell logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = mem_addr;
        data_d    = disp_data;
        daddr_d   = disp_addr;
        valid_d   = disp_valid;
        done_d    = done;
        cnt_d     = cnt_q;
        advance_c = 1'b0;

        if (restart) begin
            // Display contents are kept so the board never blanks on restart.
            state_d = ST_ISSUE;
            addr_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (RD_LAT == 0) begin
                        data_d  = mem_rd_data;
                        daddr_d = mem_addr;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    data_d  = mem_rd_data;
                    daddr_d = mem_addr;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end

                ST_HOLD: begin
                    // Step edge and dwell expiry together still advance once.
                    advance_c = step_rise_c | (run & (cnt_q == CNT_MAX));
                    if (advance_c) begin
                        cnt_d = '0;
                        if (mem_addr != ADDR_MAX) begin
                            addr_d  = mem_addr + ADDR_W'(1);
                            state_d = ST_ISSUE;
                        end else if (WRAP != 0) begin
                            addr_d  = '0;
                            state_d = ST_ISSUE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else if (run) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    state_d = ST_STOP;
                end

                default: begin
                    state_d = ST_ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed scoreboard bench for mem_scan_reader.
// u_a: DWELL=4, RD_LAT=1, WRAP=0.  u_b: DWELL=2, RD_LAT=0, WRAP=1.
module tb_mem_scan_reader;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int unsigned   gap;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return 32'h1000_0000 + DW'(a);
    endfunction

    // DUT A signals
    logic          rst_n_a, run_a, step_a, restart_a;
    logic [AW-1:0] mem_addr_a, disp_addr_a;
    logic [DW-1:0] rd_a, disp_data_a;
    logic          disp_valid_a, done_a;

    // DUT B signals
    logic          rst_n_b, run_b, step_b, restart_b;
    logic [AW-1:0] mem_addr_b, disp_addr_b;
    logic [DW-1:0] rd_b, disp_data_b;
    logic          disp_valid_b, done_b;

    mem_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .DWELL(4), .RD_LAT(1), .WRAP(0)) u_a (
        .clk(clk), .rst_n(rst_n_a), .run(run_a), .step(step_a), .restart(restart_a),
        .mem_addr(mem_addr_a), .mem_rd_data(rd_a), .disp_data(disp_data_a),
        .disp_addr(disp_addr_a), .disp_valid(disp_valid_a), .done(done_a)
    );

    mem_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .DWELL(2), .RD_LAT(0), .WRAP(1)) u_b (
        .clk(clk), .rst_n(rst_n_b), .run(run_b), .step(step_b), .restart(restart_b),
        .mem_addr(mem_addr_b), .mem_rd_data(rd_b), .disp_data(disp_data_b),
        .disp_addr(disp_addr_b), .disp_valid(disp_valid_b), .done(done_b)
    );

    // Mem models: registered read for A, combinational read for B.
    always @(posedge clk) rd_a <= word_of(mem_addr_a);
    assign rd_b = word_of(mem_addr_b);

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int unsigned first, input int unsigned last,
                          input int unsigned gap0, input int unsigned gap);
        for (int unsigned i = first; i <= last; i++) begin
            exp_t e;
            e.addr = AW'(i);
            e.data = word_of(AW'(i));
            e.gap  = (i == first) ? gap0 : gap;
            sb_a.push_back(e);
        end
    endtask

    task automatic push_b(input int unsigned first, input int unsigned last,
                          input int unsigned gap0, input int unsigned gap);
        for (int unsigned i = first; i <= last; i++) begin
            exp_t e;
            e.addr = AW'(i);
            e.data = word_of(AW'(i));
            e.gap  = (i == first) ? gap0 : gap;
            sb_b.push_back(e);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_empty_a(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (sb_a.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(sb_a.size()), 64'd0);
    endtask

    task automatic wait_empty_b(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (sb_b.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(sb_b.size()), 64'd0);
    endtask

    // Capture monitors: a new valid word or a change of shown word is a capture.
    logic          pv_a = 1'b0, pv_b = 1'b0;
    logic [AW-1:0] pa_a, pa_b;
    logic [DW-1:0] pd_a, pd_b;
    int unsigned   lc_a = 0, lc_b = 0;
    exp_t          ea, eb;

    always @(negedge clk) begin
        if (disp_valid_a === 1'b1 && (!pv_a || disp_addr_a !== pa_a || disp_data_a !== pd_a)) begin
            check("a_capture_expected", 64'(sb_a.size() != 0), 64'd1);
            if (sb_a.size() != 0) begin
                ea = sb_a.pop_front();
                check("a_disp_addr", 64'(disp_addr_a), 64'(ea.addr));
                check("a_disp_data", 64'(disp_data_a), 64'(ea.data));
                if (ea.gap != 0) check("a_capture_gap", 64'(cyc - lc_a), 64'(ea.gap));
            end
            lc_a = cyc;
        end
        pv_a = (disp_valid_a === 1'b1);
        pa_a = disp_addr_a;
        pd_a = disp_data_a;
    end

    always @(negedge clk) begin
        if (disp_valid_b === 1'b1 && (!pv_b || disp_addr_b !== pa_b || disp_data_b !== pd_b)) begin
            check("b_capture_expected", 64'(sb_b.size() != 0), 64'd1);
            if (sb_b.size() != 0) begin
                eb = sb_b.pop_front();
                check("b_disp_addr", 64'(disp_addr_b), 64'(eb.addr));
                check("b_disp_data", 64'(disp_data_b), 64'(eb.data));
                if (eb.gap != 0) check("b_capture_gap", 64'(cyc - lc_b), 64'(eb.gap));
            end
            lc_b = cyc;
        end
        pv_b = (disp_valid_b === 1'b1);
        pa_b = disp_addr_b;
        pd_b = disp_data_b;
    end

    initial begin
        rst_n_a = 1'b0; run_a = 1'b1; step_a = 1'b0; restart_a = 1'b0;
        rst_n_b = 1'b0; run_b = 1'b1; step_b = 1'b0; restart_b = 1'b0;
        tick(3);

        // Reset state
        check("a_rst_mem_addr",   64'(mem_addr_a),   64'd0);
        check("a_rst_disp_valid", 64'(disp_valid_a), 64'd0);
        check("a_rst_disp_addr",  64'(disp_addr_a),  64'd0);
        check("a_rst_disp_data",  64'(disp_data_a),  64'd0);
        check("a_rst_done",       64'(done_a),       64'd0);
        check("b_rst_disp_valid", 64'(disp_valid_b), 64'd0);

        // Free-run, RD_LAT=1: first word two cycles after release, then every 6
        push_a(0, 5, 0, 6);
        rst_n_a = 1'b1;
        tick(1);
        check("a_lat_cycle1_valid", 64'(disp_valid_a), 64'd0);
        tick(1);
        check("a_lat_cycle2_valid", 64'(disp_valid_a), 64'd1);
        wait_empty_a(60, "a_words_0_to_5");
        run_a = 1'b0;

        // Paused: held step advances exactly once
        tick(3);
        check("a_paused_addr5", 64'(disp_addr_a), 64'd5);
        push_a(6, 6, 0, 0);
        step_a = 1'b1;
        tick(10);
        check("a_step_held_once", 64'(disp_addr_a), 64'd6);
        step_a = 1'b0;
        tick(2);
        push_a(7, 7, 0, 0);
        step_a = 1'b1;
        tick(1);
        step_a = 1'b0;
        wait_empty_a(10, "a_second_step");
        tick(1000);
        check("a_frozen_disp_addr", 64'(disp_addr_a), 64'd7);
        check("a_frozen_mem_addr",  64'(mem_addr_a),  64'd7);

        // Step edge in the dwell-expiry cycle: single advance 7 -> 8
        push_a(8, 8, 0, 0);
        run_a = 1'b1;
        tick(3);
        step_a = 1'b1;
        wait_empty_a(10, "a_expiry_and_step");
        run_a = 1'b0;
        tick(12);
        check("a_single_advance", 64'(disp_addr_a), 64'd8);
        step_a = 1'b0;
        tick(1);

        // Step edge during WAIT is ignored
        push_a(9, 9, 0, 0);
        run_a = 1'b1;
        tick(5);
        step_a = 1'b1;
        wait_empty_a(10, "a_dwell_to_9");
        run_a = 1'b0;
        tick(10);
        check("a_wait_edge_ignored", 64'(disp_addr_a), 64'd9);
        check("a_wait_edge_mem",     64'(mem_addr_a),  64'd9);
        step_a = 1'b0;

        // Reset mid-scan in HOLD at address 20
        run_a = 1'b1;
        push_a(10, 20, 0, 6);
        wait_empty_a(100, "a_words_10_to_20");
        rst_n_a = 1'b0;
        tick(1);
        rst_n_a = 1'b1;
        check("a_midrst_disp_valid", 64'(disp_valid_a), 64'd0);
        check("a_midrst_mem_addr",   64'(mem_addr_a),   64'd0);
        check("a_midrst_disp_data",  64'(disp_data_a),  64'd0);

        // Reset wins over a simultaneous restart
        push_a(0, 0, 0, 0);
        wait_empty_a(10, "a_after_midrst_word0");
        tick(2);
        rst_n_a = 1'b0;
        restart_a = 1'b1;
        tick(1);
        rst_n_a = 1'b0;
        restart_a = 1'b0;
        check("a_rst_over_restart_valid", 64'(disp_valid_a), 64'd0);
        check("a_rst_over_restart_data",  64'(disp_data_a),  64'd0);
        tick(1);

        // Full pass with WRAP=0: stop at 63 with done
        push_a(0, 63, 0, 6);
        rst_n_a = 1'b1;
        wait_empty_a(500, "a_full_pass");
        check("a_done_before_expiry", 64'(done_a), 64'd0);
        tick(10);
        check("a_done_set",       64'(done_a),      64'd1);
        check("a_stop_disp_addr", 64'(disp_addr_a), 64'd63);
        check("a_stop_disp_data", 64'(disp_data_a), 64'h1000_003F);
        tick(100);
        check("a_stop_hold_done", 64'(done_a),      64'd1);
        check("a_stop_hold_data", 64'(disp_data_a), 64'h1000_003F);

        // Restart out of STOP keeps the shown word until the re-read
        push_a(0, 0, 0, 0);
        restart_a = 1'b1;
        tick(1);
        restart_a = 1'b0;
        check("a_restart_done",       64'(done_a),       64'd0);
        check("a_restart_mem_addr",   64'(mem_addr_a),   64'd0);
        check("a_restart_disp_valid", 64'(disp_valid_a), 64'd1);
        check("a_restart_disp_data",  64'(disp_data_a),  64'h1000_003F);
        wait_empty_a(10, "a_restart_word0");
        run_a = 1'b0;

        // RD_LAT=0, WRAP=1, DWELL=2: one-cycle latency, wrap 63 -> 0
        push_b(0, 63, 0, 3);
        push_b(0, 1, 3, 3);
        rst_n_b = 1'b1;
        tick(1);
        check("b_lat_cycle1_valid", 64'(disp_valid_b), 64'd1);
        check("b_lat_cycle1_addr",  64'(disp_addr_b),  64'd0);
        wait_empty_b(300, "b_wrap_pass");
        check("b_done_stays_low", 64'(done_b),      64'd0);
        check("b_after_wrap",     64'(disp_addr_b), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
